// File: rtl/alu_pkg.sv
// Shared definitions for the UART ALU packet engine: opcodes, FSM states,
// header constants and the reduce-operation helper.
package alu_pkg;

   localparam int HEADER_BYTES = 4;
   localparam int LEN_WIDTH    = 16;

   typedef enum logic [7:0] {
      OP_ADD  = 8'h01,
      OP_SUB  = 8'h02,
      OP_AND  = 8'h03,
      OP_OR   = 8'h04,
      OP_XOR  = 8'h05,
      OP_ECHO = 8'hEC
   } opcode_t;

   typedef enum logic [2:0] {
      ST_OPCODE,
      ST_RSVD,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_PAYLOAD,
      ST_DRAIN,
      ST_RESULT
   } state_t;

   // True for every opcode the engine knows how to execute.
   function automatic logic is_known_op(input logic [7:0] op);
      logic known;
      case (op)
         OP_ECHO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: known = 1'b1;
         default:                                        known = 1'b0;
      endcase
      return known;
   endfunction

   // Combines an accumulator with one operand. Computed at 64 bits; the
   // caller truncates to its operand width, which keeps add/sub modulo 2^W.
   function automatic logic [63:0] reduce_op(input logic [7:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
      logic [63:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Gathers payload bytes into little-endian operand words. A word is presented
// in the same cycle as the byte that completes it; flush_i presents a partial
// word early with its missing upper bytes as zero.
module alu_operand_collector import alu_pkg::*; #(
   parameter int OPERAND_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic [7:0]               byte_i,
   input  logic                     byte_valid_i,
   input  logic                     flush_i,
   output logic [OPERAND_WIDTH-1:0] word_o,
   output logic                     word_valid_o
);

   localparam int NB    = OPERAND_WIDTH / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   logic [OPERAND_WIDTH-1:0] lanes_q;
   logic [IDX_W-1:0]         idx_q;
   logic [OPERAND_WIDTH-1:0] byte_lane;

   // Place the incoming byte in its lane and merge it with the bytes so far.
   always_comb begin
      byte_lane    = OPERAND_WIDTH'(byte_i) << {idx_q, 3'b000};
      word_o       = lanes_q | byte_lane;
      word_valid_o = byte_valid_i & ((idx_q == LAST_IDX) | flush_i);
   end

   // Hold the partial word; restart empty after each emitted word.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         lanes_q <= '0;
         idx_q   <= '0;
      end else if (byte_valid_i) begin
         if (word_valid_o) begin
            lanes_q <= '0;
            idx_q   <= '0;
         end else begin
            lanes_q <= word_o;
            idx_q   <= idx_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_packet_engine.sv
// Packet-processing core of the UART ALU. Parses opcode/reserved/length
// headers, echoes or reduces the payload and serialises the result LSB first.
// Handshake rule on both streams: a byte transfers on a rising clk_i edge
// where tvalid and tready are both high; a valid byte is held stable until
// it transfers.
module alu_packet_engine import alu_pkg::*; #(
   parameter int OPERAND_WIDTH = 32
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       busy_o,
   output logic       error_o
);

   localparam int NB = OPERAND_WIDTH / 8;

   // state_q is left as a plain named register so checkers can observe it.
   state_t                   state_q;
   logic [7:0]               opcode_q;
   logic [7:0]               len_lo_q;
   logic [LEN_WIDTH-1:0]     cnt_q;
   logic [OPERAND_WIDTH-1:0] acc_q;
   logic                     first_q;
   logic [OPERAND_WIDTH-1:0] res_q;
   logic [3:0]               res_cnt_q;
   logic                     error_q;

   logic                     echo_pass;
   logic                     reduce_pay;
   logic                     s_hs;
   logic                     m_hs;
   logic                     last_byte;
   logic [LEN_WIDTH-1:0]     len_full;
   logic [OPERAND_WIDTH-1:0] word;
   logic                     word_valid;
   logic [OPERAND_WIDTH-1:0] acc_next;

   // Decode the current payload mode and the stream handshakes.
   always_comb begin
      echo_pass  = (state_q == ST_PAYLOAD) && (opcode_q == OP_ECHO);
      reduce_pay = (state_q == ST_PAYLOAD) && (opcode_q != OP_ECHO);
      s_hs       = s_axis_tvalid & s_axis_tready;
      m_hs       = m_axis_tvalid & m_axis_tready;
      last_byte  = (cnt_q == LEN_WIDTH'(1));
      len_full   = {s_axis_tdata, len_lo_q};
   end

   // Input readiness: echo borrows the transmitter's ready, RESULT blocks input.
   always_comb begin
      case (state_q)
         ST_RESULT:  s_axis_tready = 1'b0;
         ST_PAYLOAD: s_axis_tready = (opcode_q == OP_ECHO) ? m_axis_tready : 1'b1;
         default:    s_axis_tready = 1'b1;
      endcase
   end

   // Output stream: echo passes through, RESULT drives the serialiser register.
   always_comb begin
      if (echo_pass) begin
         m_axis_tdata  = s_axis_tdata;
         m_axis_tvalid = s_axis_tvalid;
      end else if (state_q == ST_RESULT) begin
         m_axis_tdata  = res_q[7:0];
         m_axis_tvalid = 1'b1;
      end else begin
         m_axis_tdata  = 8'h00;
         m_axis_tvalid = 1'b0;
      end
      busy_o  = (state_q != ST_OPCODE);
      error_o = error_q;
   end

   alu_operand_collector #(
      .OPERAND_WIDTH (OPERAND_WIDTH)
   ) u_collector (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      ((state_q == ST_LEN_HI) && s_hs),
      .byte_i       (s_axis_tdata),
      .byte_valid_i (reduce_pay && s_hs),
      .flush_i      (last_byte),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   // Accumulator update: the first operand loads, later ones are reduced in.
   always_comb begin
      acc_next = acc_q;
      if (word_valid) begin
         if (first_q) acc_next = word;
         else acc_next = OPERAND_WIDTH'(reduce_op(opcode_q, 64'(acc_q), 64'(word)));
      end
   end

   // Packet FSM with payload counter, accumulator and result serialiser.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_OPCODE;
         opcode_q  <= 8'h00;
         len_lo_q  <= 8'h00;
         cnt_q     <= '0;
         acc_q     <= '0;
         first_q   <= 1'b1;
         res_q     <= '0;
         res_cnt_q <= '0;
         error_q   <= 1'b0;
      end else begin
         error_q <= 1'b0;
         acc_q   <= acc_next;
         if (word_valid) first_q <= 1'b0;
         case (state_q)
            ST_OPCODE: begin
               if (s_hs) begin
                  opcode_q <= s_axis_tdata;
                  state_q  <= ST_RSVD;
               end
            end
            ST_RSVD: begin
               if (s_hs) state_q <= ST_LEN_LO;
            end
            ST_LEN_LO: begin
               if (s_hs) begin
                  len_lo_q <= s_axis_tdata;
                  state_q  <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (s_hs) begin
                  cnt_q   <= len_full - LEN_WIDTH'(HEADER_BYTES);
                  acc_q   <= '0;
                  first_q <= 1'b1;
                  if (len_full < LEN_WIDTH'(HEADER_BYTES)) begin
                     error_q <= 1'b1;
                     state_q <= ST_OPCODE;
                  end else if (!is_known_op(opcode_q)) begin
                     // An unknown opcode with no payload has nothing to drain.
                     error_q <= 1'b1;
                     state_q <= (len_full == LEN_WIDTH'(HEADER_BYTES)) ? ST_OPCODE : ST_DRAIN;
                  end else if (len_full == LEN_WIDTH'(HEADER_BYTES)) begin
                     if (opcode_q == OP_ECHO) begin
                        state_q <= ST_OPCODE;
                     end else begin
                        res_q     <= '0;
                        res_cnt_q <= 4'(NB);
                        state_q   <= ST_RESULT;
                     end
                  end else begin
                     state_q <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (s_hs) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (last_byte) begin
                     if (opcode_q == OP_ECHO) begin
                        state_q <= ST_OPCODE;
                     end else begin
                        // The last operand is folded in this cycle, so load acc_next.
                        res_q     <= acc_next;
                        res_cnt_q <= 4'(NB);
                        state_q   <= ST_RESULT;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (s_hs) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (last_byte) state_q <= ST_OPCODE;
               end
            end
            ST_RESULT: begin
               if (m_hs) begin
                  res_q     <= res_q >> 8;
                  res_cnt_q <= res_cnt_q - 1'b1;
                  if (res_cnt_q == 4'd1) state_q <= ST_OPCODE;
               end
            end
            default: state_q <= ST_OPCODE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Bench for alu_packet_engine: a 32-bit and a 16-bit instance share the input
// stream; sel16 chooses which one is fed and observed.
module tb_alu_packet_engine;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       m_tready;
   logic       sel16;
   int         tr_mode;

   logic       s_tready32, m_tvalid32, busy32, err32;
   logic [7:0] m_tdata32;
   logic       s_tready16, m_tvalid16, busy16, err16;
   logic [7:0] m_tdata16;

   logic       s_tready, m_tvalid, busy, err_o;
   logic [7:0] m_tdata;

   assign s_tready = sel16 ? s_tready16 : s_tready32;
   assign m_tvalid = sel16 ? m_tvalid16 : m_tvalid32;
   assign m_tdata  = sel16 ? m_tdata16  : m_tdata32;
   assign busy     = sel16 ? busy16     : busy32;
   assign err_o    = sel16 ? err16      : err32;

   alu_packet_engine #(.OPERAND_WIDTH(32)) dut32 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid & ~sel16),
      .s_axis_tready (s_tready32),
      .m_axis_tdata  (m_tdata32),
      .m_axis_tvalid (m_tvalid32),
      .m_axis_tready (m_tready),
      .busy_o        (busy32),
      .error_o       (err32)
   );

   alu_packet_engine #(.OPERAND_WIDTH(16)) dut16 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid & sel16),
      .s_axis_tready (s_tready16),
      .m_axis_tdata  (m_tdata16),
      .m_axis_tvalid (m_tvalid16),
      .m_axis_tready (m_tready),
      .busy_o        (busy16),
      .error_o       (err16)
   );

   // ---------------- bookkeeping ----------------
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         err_exp  = 0;
   int         err_seen = 0;
   int         err_high = 0;
   logic       err_prev = 1'b0;
   logic       hold_pending = 1'b0;
   logic [7:0] hold_data = 8'h00;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic known_op(input logic [7:0] op);
      return op inside {8'hEC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pending = 1'b0;
         err_prev     = 1'b0;
      end else begin
         if (hold_pending) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, hold_data);
         end
         if (m_tvalid && m_tready) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_byte: got %02h expected none", m_tdata);
            end
            if (exp_q.size() != 0) chk("out_byte", m_tdata, exp_q.pop_front());
         end
         hold_pending = m_tvalid && !m_tready;
         hold_data    = m_tdata;
         if (err_o) err_high++;
         if (err_o && !err_prev) err_seen++;
         err_prev = err_o;
      end
   end

   // ---------------- transmitter ready pattern ----------------
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (tr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- reference model ----------------
   task automatic model(input logic [7:0] op, input logic [15:0] len,
                        input logic [7:0] pl[$], input int nb);
      longint unsigned acc, opnd, mask;
      int n, k, idx;
      if (len < 16'd4 || !known_op(op)) begin
         err_exp++;
         return;
      end
      if (op == 8'hEC) begin
         foreach (pl[i]) exp_q.push_back(pl[i]);
         return;
      end
      n    = pl.size();
      k    = (n + nb - 1) / nb;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      acc  = 0;
      for (int j = 0; j < k; j++) begin
         opnd = 0;
         for (int i = 0; i < nb; i++) begin
            idx = j * nb + i;
            if (idx < n) opnd = opnd | (longint'(pl[idx]) << (8 * i));
         end
         if (j == 0) acc = opnd;
         else begin
            case (op)
               8'h01:   acc = acc + opnd;
               8'h02:   acc = acc - opnd;
               8'h03:   acc = acc & opnd;
               8'h04:   acc = acc | opnd;
               default: acc = acc ^ opnd;
            endcase
         end
         acc = acc & mask;
      end
      for (int i = 0; i < nb; i++) exp_q.push_back(8'((acc >> (8 * i)) & 64'hFF));
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      s_tdata  = b;
      s_tvalid = 1'b1;
      do begin
         @(negedge clk);
         k++;
      end while (!s_tready && k < 200);
      chk("send_ready", s_tready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [7:0] op, input logic [15:0] len, input logic [7:0] pl[$]);
      send_byte(op);
      send_byte(8'h00);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      foreach (pl[i]) send_byte(pl[i]);
      s_tvalid = 1'b0;
      if (len < 16'd4) begin
         chk("short_len_error", err_o, 1);
         chk("short_len_idle", busy, 0);
      end else if (known_op(op) && op != 8'hEC) begin
         chk("result_latency", m_tvalid, 1);
      end else begin
         chk("no_output_after_last", m_tvalid, 0);
      end
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 500) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_drained"}, exp_q.size(), 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_err_count"}, err_seen, err_exp);
      chk({tag, "_err_width"}, err_high, err_exp);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      logic [7:0]  pl[$];
      logic [7:0]  op;
      logic [15:0] len;
      logic [7:0]  bad_ops[4];
      logic [7:0]  good_ops[6];
      int          r, n;

      bad_ops  = '{8'h00, 8'h7F, 8'hFF, 8'h06};
      good_ops = '{8'hEC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      tr_mode  = 0;
      sel16    = 1'b0;
      s_tdata  = 8'h00;
      s_tvalid = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", s_tready, 1);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", err_o, 0);
      chk("rst_tready16", s_tready16, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Echo
      pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_pkt(8'hEC, 16'd8, pl);
      wait_idle("echo");

      // Add with wrap-around, then with a toggling transmitter
      pl = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_q = '{8'h04, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h01, 16'd12, pl);
      wait_idle("add_wrap");
      tr_mode = 1;
      exp_q = '{8'h04, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h01, 16'd12, pl);
      wait_idle("add_toggle");
      tr_mode = 0;

      // Sub over three operands, then an empty add
      pl = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      exp_q = '{8'h05, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h02, 16'd16, pl);
      wait_idle("sub3");
      pl = {};
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h01, 16'd4, pl);
      wait_idle("add_empty");

      // 16-bit instance, xor with a trailing partial operand
      sel16 = 1'b1;
      pl = '{8'hFF, 8'h00, 8'h0F};
      exp_q = '{8'hF0, 8'h00};
      send_pkt(8'h05, 16'd7, pl);
      wait_idle("xor16_partial");
      sel16 = 1'b0;

      // Unknown opcode is drained, then a normal add, then a short length
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      err_exp++;
      send_pkt(8'h7F, 16'd8, pl);
      wait_idle("unknown_op");
      pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      exp_q = '{8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h01, 16'd12, pl);
      wait_idle("add_after_err");
      pl = {};
      err_exp++;
      send_pkt(8'h01, 16'd2, pl);
      wait_idle("short_len");

      // Reset in the middle of an add packet
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h0C);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h00);
      s_tvalid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_tready", s_tready, 1);
      chk("midrst_tvalid", m_tvalid, 0);
      chk("midrst_tdata", m_tdata, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_error", err_o, 0);
      pl = '{8'h12, 8'h34};
      exp_q = '{8'h12, 8'h34};
      send_pkt(8'hEC, 16'd6, pl);
      wait_idle("echo_after_rst");

      // Randomised packets against the reference model
      for (int p = 0; p < 40; p++) begin
         sel16   = 1'($urandom_range(0, 1));
         tr_mode = $urandom_range(0, 2);
         r = $urandom_range(0, 8);
         op = (r < 6) ? good_ops[r] : bad_ops[$urandom_range(0, 3)];
         pl = {};
         if ($urandom_range(0, 7) == 0) begin
            len = 16'($urandom_range(0, 3));
         end else begin
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
            len = 16'(n + 4);
         end
         model(op, len, pl, sel16 ? 2 : 4);
         send_pkt(op, len, pl);
         wait_idle("rand");
      end
      tr_mode = 0;
      sel16   = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Overall time bound
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_packet_engine.md
# alu_packet_engine

Parametrised packet-processing core of the UART ALU, placed between the `uart_rx` master stream and the `uart_tx` slave stream. It parses framed byte packets (opcode, reserved, 16-bit length) and runs one of several operations on the payload:

- echo the payload unchanged, or
- reduce the payload's little-endian operands to one result and send it back as `OPERAND_WIDTH/8` bytes, LSB first.

It generalises the fixed 32-bit echo/add engine to any byte-multiple operand width and a wider opcode set, and adds explicit error reporting.

## Interface
- `OPERAND_WIDTH`, default 32: operand and result width in bits; must be a multiple of 8, range 8–64.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: synchronous, active-low reset.
- `s_axis_tdata`  in  8: received byte.
- `s_axis_tvalid`  in  1: received byte valid.
- `s_axis_tready`  out  1: engine accepts the byte.
- `m_axis_tdata`  out  8: byte to transmit.
- `m_axis_tvalid`  out  1: transmit byte valid.
- `m_axis_tready`  in  1: transmitter accepts the byte.
- `busy_o`  out  1: high in any state other than OPCODE.
- `error_o`  out  1: one-cycle pulse on an unknown opcode or a length field below 4.

## Operation
- **Packet format:** opcode, reserved byte (ignored), length LSB, length MSB, then payload. The length field counts the 4 header bytes, so payload bytes = length − 4.
- **Opcodes:**
  - 0xEC: echo.
  - 0x01: add.
  - 0x02: sub (first operand minus all the others).
  - 0x03: and.
  - 0x04: or.
  - 0x05: xor.
  - Any other value: unknown.
- **States:** OPCODE → RSVD → LEN_LO → LEN_HI → {PAYLOAD | DRAIN} → RESULT → OPCODE.
  - Echo never enters RESULT; it returns to OPCODE after its last payload byte.
  - A state advances only on an `s_axis` handshake, except RESULT, which advances on `m_axis` handshakes.
- **LEN_HI exit:**
  - If length < 4: pulse `error_o` and go to OPCODE (no output).
  - Else if the opcode is unknown: pulse `error_o` and go to DRAIN, which consumes and discards the payload bytes.
  - Else if the payload is empty: echo goes to OPCODE; reduce ops go to RESULT with result 0.
  - Else go to PAYLOAD.
- **Echo PAYLOAD (combinational pass-through):**
  - `m_axis_tdata` = `s_axis_tdata`
  - `m_axis_tvalid` = `s_axis_tvalid`
  - `s_axis_tready` = `m_axis_tready`
- **Reduce PAYLOAD:**
  - Bytes are shifted into an operand register, little-endian.
  - When byte `OPERAND_WIDTH/8 − 1` of an operand is accepted, the operand is combined into the accumulator in that same cycle. The first operand of a packet loads the accumulator directly.
  - A trailing partial operand (payload not a multiple of the operand size) is zero-extended in its upper bytes and combined when the last payload byte is accepted.
- **Arithmetic:** add and sub are modulo 2^`OPERAND_WIDTH`; carry and borrow are discarded. No signed/unsigned distinction.
- **RESULT:** emits the accumulator bytes LSB first; `m_axis_tdata` stays stable until its handshake.
- **Payload counter:** 16 bits, loaded with length − 4 in LEN_HI, decremented on each accepted payload byte. The final byte is the one accepted when the counter equals 1.

## Timing
- **Reset values:**
  - State = OPCODE.
  - `s_axis_tready` = 1.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0.
  - `busy_o` = 0, `error_o` = 0.
  - Accumulator, operand register and counters = 0.
- **Reset mid-packet:** the partial packet is discarded and all of the above values hold from the next edge. A result byte in flight is dropped.
- `s_axis_tready` is 1 in OPCODE, RSVD, LEN_LO, LEN_HI, DRAIN and reduce PAYLOAD; it equals `m_axis_tready` in echo PAYLOAD and is 0 in RESULT.
- **Result latency:** the first result byte is valid in the cycle after the last payload handshake, or after LEN_HI for an empty payload. Each later byte is valid in the cycle after the previous byte's handshake.
- **Throughput:** header, drain and reduce payload bytes are accepted one per cycle. A new opcode is accepted in the cycle after the final RESULT handshake.
- `error_o` is asserted in the cycle after the LEN_HI handshake, for exactly one cycle.

## Structure
- **Shared package `alu_pkg`:** opcode enum (`OP_ECHO` = 8'hEC, `OP_ADD` = 8'h01, `OP_SUB` through `OP_XOR`), state enum, `HEADER_BYTES` = 4, `LEN_WIDTH` = 16.
- **Sub-module `alu_operand_collector` (parametrised by `OPERAND_WIDTH`):**
  - Byte shift-in register with byte index.
  - Outputs `word_o` and `word_valid_o`.
  - `flush_i` forces out a zero-extended partial word.
- **Top level:** FSM, payload counter, accumulator with reduce mux, and result serialiser.

## Test plan
1. **Echo:** EC 00 08 00 DE AD BE EF → out DE AD BE EF, no further bytes; `busy_o` low afterwards.
2. **Add, wrap-around:** 01 00 0C 00, operands 0x00000005 and 0xFFFFFFFF → out 04 00 00 00. Repeat with `m_axis_tready` toggling every other cycle → same bytes, each held stable until its handshake.
3. **Sub, three operands:** 02 00 10 00, operands 10, 3, 2 → 05 00 00 00. Add with length 4 → 00 00 00 00.
4. **Narrow width and partial operand:** `OPERAND_WIDTH` = 16; xor 05 00 07 00, payload FF 00 0F → 0x00FF ^ 0x000F = 0x00F0 → out F0 00.
5. **Error recovery:** 7F 00 08 00 11 22 33 44 → `error_o` pulses once, no output. Then 01 00 0C 00 with operands 1 and 2 → 03 00 00 00. Separately, length 0x0002 → `error_o` pulse, engine back in OPCODE.
6. **Reset mid-packet:** assert `rst_ni` low for 1 cycle after the 6th byte of an add packet → outputs at their reset values next cycle. A fresh echo packet then works correctly.
